// File: rtl/expr_lane_pipe_if.sv
// rtl/expr_lane_pipe_if.sv - operand/result handshake bundle for expr_lane_pipe
//
// Purpose: groups the request channel (in_valid/in_ready, op, sgn, a, b) and
// the response channel (out_valid/out_ready, y, ovf) of one expr_lane_pipe.
// Ports (signals):
//   in_valid, in_ready      request handshake
//   op[2:0], sgn            operator select, signed interpretation
//   a, b [LANES*WIDTH]      packed per-lane operands
//   out_valid, out_ready    response handshake
//   y [LANES*OUT_W]         packed per-lane results
//   ovf [LANES]             per-lane overflow flags
// Modports: master = producer/consumer harness, slave = the pipeline.

interface expr_lane_pipe_if #(
   parameter int WIDTH = 6,
   parameter int LANES = 4,
   parameter int OUT_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [2:0]               op;
   logic                     sgn;
   logic [LANES*WIDTH-1:0]   a;
   logic [LANES*WIDTH-1:0]   b;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*OUT_W-1:0]   y;
   logic [LANES-1:0]         ovf;

   modport master (
      output in_valid, op, sgn, a, b, out_ready,
      input  in_ready, out_valid, y, ovf
   );

   modport slave (
      input  in_valid, op, sgn, a, b, out_ready,
      output in_ready, out_valid, y, ovf
   );
endinterface

// File: rtl/expr_lane_pipe.sv
// rtl/expr_lane_pipe.sv - two-stage per-lane mixed-signedness expression pipeline
//
// Purpose: evaluates one operator on LANES independent operand pairs per
// transaction. S1 registers op/sgn and operands extended to OUT_W bits;
// S2 computes each lane and registers y/ovf/out_valid.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (clears valids, y and ovf)
//   bus     expr_lane_pipe_if slave: request and response handshakes
// Parameters: WIDTH operand width, LANES lane count, OUT_W result width
// (OUT_W >= WIDTH), SAT 1 = add/sub/mul clamp, 0 = wrap.

module expr_lane_pipe #(
   parameter int WIDTH = 6,
   parameter int LANES = 4,
   parameter int OUT_W = 8,
   parameter bit SAT   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   expr_lane_pipe_if.slave bus
);
   // Wide enough for the exact product of two (OUT_W+1)-bit signed values,
   // so zero-extended unsigned operands never appear negative.
   localparam int FW = 2*OUT_W + 2;

   logic                   stall;
   logic                   s1_valid;
   logic [2:0]             s1_op;
   logic                   s1_sgn;
   logic [OUT_W-1:0]       s1_a [LANES];
   logic [OUT_W-1:0]       s1_b [LANES];
   logic [OUT_W-1:0]       a_ext [LANES];
   logic [OUT_W-1:0]       b_ext [LANES];
   logic [OUT_W:0]         res [LANES];
   logic                   out_valid_q;
   logic [LANES*OUT_W-1:0] y_q;
   logic [LANES*OUT_W-1:0] y_nxt;
   logic [LANES-1:0]       ovf_q;
   logic [LANES-1:0]       ovf_nxt;

   // Returns {ovf, y} for one lane from the already-extended operands.
   function automatic logic [OUT_W:0] lane_eval(
      input logic [2:0]       o,
      input logic             s,
      input logic [OUT_W-1:0] ea,
      input logic [OUT_W-1:0] eb
   );
      logic signed [FW-1:0] xa;
      logic signed [FW-1:0] xb;
      logic signed [FW-1:0] r;
      logic signed [FW-1:0] lo;
      logic signed [FW-1:0] hi;
      logic [OUT_W-1:0]     yl;
      logic [OUT_W-1:0]     back;
      logic                 ol;

      r    = '0;
      yl   = '0;
      back = '0;
      ol   = 1'b0;
      if (s) begin
         xa = FW'($signed(ea));
         xb = FW'($signed(eb));
         lo = {{(FW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
         hi = {{(FW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      end else begin
         xa = FW'(ea);
         xb = FW'(eb);
         lo = '0;
         hi = {{(FW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
      end

      case (o)
         3'd0, 3'd1, 3'd2: begin
            if (o == 3'd0)      r = xa + xb;
            else if (o == 3'd1) r = xa - xb;
            else                r = xa * xb;
            ol = (r < lo) || (r > hi);
            yl = r[OUT_W-1:0];
            if (SAT) begin
               if (r < lo)      yl = lo[OUT_W-1:0];
               else if (r > hi) yl = hi[OUT_W-1:0];
            end
         end
         3'd3: begin
            // Overflow iff shifting the result back does not restore the
            // operand: the lost bits were not all equal to the refill value.
            yl = ea << eb;
            if (s) back = $unsigned($signed(yl) >>> eb);
            else   back = yl >> eb;
            ol = (back != ea);
         end
         3'd4: begin
            if (s) yl = $unsigned($signed(ea) >>> eb);
            else   yl = ea >> eb;
         end
         3'd5: begin
            if (s) yl = {{(OUT_W-1){1'b0}}, ($signed(ea) < $signed(eb))};
            else   yl = {{(OUT_W-1){1'b0}}, (ea < eb)};
         end
         3'd6: yl = {{(OUT_W-1){1'b0}}, (ea == eb)};
         default: yl = {{(OUT_W-1){1'b0}}, ~^(ea ^ eb)};
      endcase
      return {ol, yl};
   endfunction

   assign stall         = out_valid_q & ~bus.out_ready;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         if (bus.sgn) begin
            a_ext[i] = OUT_W'($signed(bus.a[i*WIDTH +: WIDTH]));
            b_ext[i] = OUT_W'($signed(bus.b[i*WIDTH +: WIDTH]));
         end else begin
            a_ext[i] = OUT_W'(bus.a[i*WIDTH +: WIDTH]);
            b_ext[i] = OUT_W'(bus.b[i*WIDTH +: WIDTH]);
         end
      end
   end

   always_comb begin
      y_nxt   = '0;
      ovf_nxt = '0;
      for (int i = 0; i < LANES; i++) begin
         res[i]                    = lane_eval(s1_op, s1_sgn, s1_a[i], s1_b[i]);
         y_nxt[i*OUT_W +: OUT_W]   = res[i][OUT_W-1:0];
         ovf_nxt[i]                = res[i][OUT_W];
      end
   end

   // Both stages advance together; a stall freezes everything so y/ovf
   // stay stable and no accepted transaction is overwritten.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_op       <= '0;
         s1_sgn      <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         ovf_q       <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_a[i] <= '0;
            s1_b[i] <= '0;
         end
      end else if (!stall) begin
         s1_valid    <= bus.in_valid;
         s1_op       <= bus.op;
         s1_sgn      <= bus.sgn;
         for (int i = 0; i < LANES; i++) begin
            s1_a[i] <= a_ext[i];
            s1_b[i] <= b_ext[i];
         end
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            y_q   <= y_nxt;
            ovf_q <= ovf_nxt;
         end
      end
   end
endmodule

// File: tb/tb_expr_lane_pipe.sv
// tb/tb_expr_lane_pipe.sv - scoreboard bench for expr_lane_pipe (wrap and saturating builds)

module tb_expr_lane_pipe;
   localparam int WIDTH = 6;
   localparam int LANES = 4;
   localparam int OUT_W = 8;

   typedef struct {
      logic [LANES*OUT_W-1:0] y;
      logic [LANES-1:0]       ovf;
      int                     cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic [2:0] op = '0;
   logic sgn = 1'b0;
   logic [LANES*WIDTH-1:0] a = '0;
   logic [LANES*WIDTH-1:0] b = '0;
   logic out_ready = 1'b1;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   bit exact_lat = 1'b0;
   bit rnd_ready = 1'b0;
   exp_t q0[$];
   exp_t q1[$];
   bit prev_stall = 1'b0;
   logic [LANES*OUT_W-1:0] prev_y0, prev_y1;
   logic [LANES-1:0] prev_o0, prev_o1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   expr_lane_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W)) bus0();
   expr_lane_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W)) bus1();

   assign bus0.in_valid = in_valid;
   assign bus0.op = op;
   assign bus0.sgn = sgn;
   assign bus0.a = a;
   assign bus0.b = b;
   assign bus0.out_ready = out_ready;
   assign bus1.in_valid = in_valid;
   assign bus1.op = op;
   assign bus1.sgn = sgn;
   assign bus1.a = a;
   assign bus1.b = b;
   assign bus1.out_ready = out_ready;

   expr_lane_pipe #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W), .SAT(1'b0))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));
   expr_lane_pipe #(.WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W), .SAT(1'b1))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   function automatic longint wrapm(input longint v, input longint m);
      return ((v % m) + m) % m;
   endfunction

   // Reference: operands as integers, exact arithmetic, then range rules.
   function automatic void model(input logic [2:0] o, input logic s,
                                 input logic [LANES*WIDTH-1:0] av, input logic [LANES*WIDTH-1:0] bv,
                                 input bit sat,
                                 output logic [LANES*OUT_W-1:0] yv, output logic [LANES-1:0] ov);
      longint m, lo, hi, va, vb, r, amt;
      bit of;
      m  = longint'(1) << OUT_W;
      lo = s ? -(m / 2) : 0;
      hi = s ? (m / 2 - 1) : (m - 1);
      yv = '0;
      ov = '0;
      for (int i = 0; i < LANES; i++) begin
         va = longint'(av[i*WIDTH +: WIDTH]);
         vb = longint'(bv[i*WIDTH +: WIDTH]);
         if (s && va >= (longint'(1) << (WIDTH-1))) va -= longint'(1) << WIDTH;
         if (s && vb >= (longint'(1) << (WIDTH-1))) vb -= longint'(1) << WIDTH;
         amt = wrapm(vb, m);
         of = 1'b0;
         r = 0;
         case (o)
            3'd0: r = va + vb;
            3'd1: r = va - vb;
            3'd2: r = va * vb;
            3'd3: begin
               if (amt >= OUT_W) begin r = 0; of = (va != 0); end
               else begin r = va * (longint'(1) << amt); of = (r < lo) || (r > hi); end
            end
            3'd4: begin
               if (amt >= OUT_W) r = (va < 0) ? -1 : 0;
               else r = va >>> amt;
            end
            3'd5: r = (va < vb) ? 1 : 0;
            3'd6: r = (va == vb) ? 1 : 0;
            default: r = (($countones(wrapm(va, m) ^ wrapm(vb, m)) % 2) == 0) ? 1 : 0;
         endcase
         if (o <= 3'd2) begin
            of = (r < lo) || (r > hi);
            if (sat && r < lo) r = lo;
            else if (sat && r > hi) r = hi;
         end
         yv[i*OUT_W +: OUT_W] = OUT_W'(wrapm(r, m));
         ov[i] = of;
      end
   endfunction

   // Monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         q0.delete();
         q1.delete();
         prev_stall = 1'b0;
      end else begin
         chk("in_ready", 64'(bus0.in_ready), 64'(!(bus0.out_valid && !out_ready)));
         if (prev_stall) begin
            chk("stall_valid", 64'(bus0.out_valid), 64'd1);
            chk("stall_y0", 64'(bus0.y), 64'(prev_y0));
            chk("stall_ovf0", 64'(bus0.ovf), 64'(prev_o0));
            chk("stall_y1", 64'(bus1.y), 64'(prev_y1));
            chk("stall_ovf1", 64'(bus1.ovf), 64'(prev_o1));
         end
         if (bus0.out_valid && out_ready) begin
            if (q0.size() == 0) chk("spurious0", 64'd1, 64'd0);
            else begin
               e = q0.pop_front();
               chk("y_wrap", 64'(bus0.y), 64'(e.y));
               chk("ovf_wrap", 64'(bus0.ovf), 64'(e.ovf));
               chk("latency_min", 64'((cyc - e.cyc) >= 2), 64'd1);
               if (exact_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
            end
         end
         if (bus1.out_valid && out_ready) begin
            if (q1.size() == 0) chk("spurious1", 64'd1, 64'd0);
            else begin
               e = q1.pop_front();
               chk("y_sat", 64'(bus1.y), 64'(e.y));
               chk("ovf_sat", 64'(bus1.ovf), 64'(e.ovf));
            end
         end
         if (in_valid && bus0.in_ready) begin
            model(op, sgn, a, b, 1'b0, e.y, e.ovf);
            e.cyc = cyc;
            q0.push_back(e);
            model(op, sgn, a, b, 1'b1, e.y, e.ovf);
            q1.push_back(e);
         end
         prev_stall = bus0.out_valid && !out_ready;
         prev_y0 = bus0.y;
         prev_o0 = bus0.ovf;
         prev_y1 = bus1.y;
         prev_o1 = bus1.ovf;
      end
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   function automatic logic [LANES*WIDTH-1:0] rnd();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[LANES*WIDTH-1:0];
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] o, input logic s,
                       input logic [LANES*WIDTH-1:0] av, input logic [LANES*WIDTH-1:0] bv);
      int n = 0;
      in_valid = 1'b1;
      op = o;
      sgn = s;
      a = av;
      b = bv;
      forever begin
         @(negedge clk);
         n++;
         if (bus0.in_ready) break;
         if (n > 200) begin
            chk("send_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus0.out_valid && n < 20);
      chk({nm, "_valid"}, 64'(bus0.out_valid), 64'd1);
   endtask

   task automatic d(input string nm, input logic [2:0] o, input logic s,
                    input logic [WIDTH-1:0] la, input logic [WIDTH-1:0] lb,
                    input logic [OUT_W-1:0] ey0, input logic eo0,
                    input logic [OUT_W-1:0] ey1, input logic eo1);
      logic [LANES*WIDTH-1:0] av, bv;
      av = rnd();
      bv = rnd();
      av[WIDTH-1:0] = la;
      bv[WIDTH-1:0] = lb;
      send(o, s, av, bv);
      wait_out(nm);
      chk({nm, "_y"}, 64'(bus0.y[OUT_W-1:0]), 64'(ey0));
      chk({nm, "_ovf"}, 64'(bus0.ovf[0]), 64'(eo0));
      chk({nm, "_ysat"}, 64'(bus1.y[OUT_W-1:0]), 64'(ey1));
      chk({nm, "_ovfsat"}, 64'(bus1.ovf[0]), 64'(eo1));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain0", 64'(q0.size()), 64'd0);
      chk("drain1", 64'(q1.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [LANES*WIDTH-1:0] av;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(bus0.out_valid), 64'd0);
      chk("rst_y", 64'(bus0.y), 64'd0);
      chk("rst_ovf", 64'(bus0.ovf), 64'd0);
      chk("rst_y_sat", 64'(bus1.y), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      exact_lat = 1'b1;
      d("add_s",   3'd0, 1'b1, 6'b111100, 6'd3,      8'hFF, 1'b0, 8'hFF, 1'b0);
      d("add_u",   3'd0, 1'b0, 6'b111100, 6'd3,      8'h3F, 1'b0, 8'h3F, 1'b0);
      d("mul_s",   3'd2, 1'b1, 6'b100000, 6'b100000, 8'h00, 1'b1, 8'h7F, 1'b1);
      d("sub_u",   3'd1, 1'b0, 6'd1,      6'd2,      8'hFF, 1'b1, 8'h00, 1'b1);
      d("shl_s",   3'd3, 1'b1, 6'd3,      6'd6,      8'hC0, 1'b1, 8'hC0, 1'b1);
      d("shl_u",   3'd3, 1'b0, 6'd3,      6'd6,      8'hC0, 1'b0, 8'hC0, 1'b0);
      d("shr_s2",  3'd4, 1'b1, 6'b100000, 6'd2,      8'hF8, 1'b0, 8'hF8, 1'b0);
      d("shr_u2",  3'd4, 1'b0, 6'b100000, 6'd2,      8'h08, 1'b0, 8'h08, 1'b0);
      d("shr_s9",  3'd4, 1'b1, 6'b100000, 6'd9,      8'hFF, 1'b0, 8'hFF, 1'b0);
      d("shr_u9",  3'd4, 1'b0, 6'b100000, 6'd9,      8'h00, 1'b0, 8'h00, 1'b0);
      d("lt_s",    3'd5, 1'b1, 6'b111111, 6'd1,      8'h01, 1'b0, 8'h01, 1'b0);
      d("lt_u",    3'd5, 1'b0, 6'b111111, 6'd1,      8'h00, 1'b0, 8'h00, 1'b0);
      av = rnd();
      send(3'd6, 1'b1, av, av);
      wait_out("ceq");
      chk("ceq_all_lanes", 64'(bus0.y), 64'h01010101);
      chk("ceq_all_lanes_sat", 64'(bus1.y), 64'h01010101);
      @(posedge clk);
      #1;
      exact_lat = 1'b0;

      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 3; i++) send(3'($urandom_range(0, 7)), 1'($urandom), rnd(), rnd());
         end
         begin
            repeat (4) @(negedge clk);
            chk("stall_in_ready", 64'(bus0.in_ready), 64'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      out_ready = 1'b0;
      send(3'd2, 1'b0, rnd(), rnd());
      send(3'd0, 1'b1, rnd(), rnd());
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst2_valid", 64'(bus0.out_valid), 64'd0);
      chk("rst2_y", 64'(bus0.y), 64'd0);
      chk("rst2_ovf", 64'(bus0.ovf), 64'd0);
      chk("rst2_y_sat", 64'(bus1.y), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exact_lat = 1'b1;
      d("post_rst", 3'd0, 1'b1, 6'b111100, 6'd3, 8'hFF, 1'b0, 8'hFF, 1'b0);
      exact_lat = 1'b0;

      rnd_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(3'($urandom_range(0, 7)), 1'($urandom), rnd(), rnd());
      end
      rnd_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
